lc3_controller: RTL and testbench

LC3_CONTROLLER -- requirements
Module: lc3_controller

---
 rtl/lc3_pkg.sv | 71 +++++++
 rtl/lc3_controller.sv | 220 ++++++++++++++++++++++
 tb/tb_lc3_controller.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/lc3_pkg.sv
// Shared definitions for the LC-3 control FSM: textbook state numbers,
// opcodes, mux-select encodings and the control word bundle.
package lc3_pkg;

    typedef enum logic [5:0] {
        S0  = 6'd0,  S1  = 6'd1,  S2  = 6'd2,  S3  = 6'd3,  S4  = 6'd4,
        S5  = 6'd5,  S6  = 6'd6,  S7  = 6'd7,  S8  = 6'd8,  S9  = 6'd9,
        S10 = 6'd10, S11 = 6'd11, S12 = 6'd12, S13 = 6'd13, S14 = 6'd14,
        S15 = 6'd15, S16 = 6'd16, S18 = 6'd18, S20 = 6'd20, S21 = 6'd21,
        S22 = 6'd22, S23 = 6'd23, S24 = 6'd24, S25 = 6'd25, S26 = 6'd26,
        S27 = 6'd27, S28 = 6'd28, S29 = 6'd29, S30 = 6'd30, S31 = 6'd31,
        S32 = 6'd32, S33 = 6'd33, S34 = 6'd34, S35 = 6'd35, S36 = 6'd36,
        S37 = 6'd37, S38 = 6'd38, S39 = 6'd39, S40 = 6'd40, S41 = 6'd41,
        S42 = 6'd42, S43 = 6'd43, S44 = 6'd44, S45 = 6'd45, S47 = 6'd47,
        S48 = 6'd48, S49 = 6'd49, S50 = 6'd50, S52 = 6'd52, S54 = 6'd54,
        S59 = 6'd59
    } state_e;

    localparam logic [3:0] OP_BR  = 4'd0,  OP_ADD = 4'd1,  OP_LD   = 4'd2,  OP_ST  = 4'd3;
    localparam logic [3:0] OP_JSR = 4'd4,  OP_AND = 4'd5,  OP_LDR  = 4'd6,  OP_STR = 4'd7;
    localparam logic [3:0] OP_RTI = 4'd8,  OP_NOT = 4'd9,  OP_LDI  = 4'd10, OP_STI = 4'd11;
    localparam logic [3:0] OP_JMP = 4'd12, OP_RES = 4'd13, OP_LEA  = 4'd14, OP_TRAP = 4'd15;

    localparam logic [1:0] ALU_ADD = 2'b00, ALU_AND = 2'b01, ALU_NOT = 2'b10, ALU_PASS = 2'b11;
    localparam logic [1:0] PC_INC = 2'b00, PC_EAB = 2'b01, PC_BUS = 2'b10;
    localparam logic       EAB1_PC = 1'b0, EAB1_SR1 = 1'b1;
    localparam logic [1:0] EAB2_ZERO = 2'b00, EAB2_OFF6 = 2'b01, EAB2_OFF9 = 2'b10, EAB2_OFF11 = 2'b11;
    localparam logic       MAR_ZEXT = 1'b0, MAR_EAB = 1'b1;
    localparam logic       MDR_BUS = 1'b0, MDR_MEM = 1'b1;
    localparam logic       PSR_BUS = 1'b0, PSR_INT = 1'b1;
    localparam logic [1:0] SP_INC = 2'b00, SP_DEC = 2'b01, SP_SSP = 2'b10, SP_USP = 2'b11;
    localparam logic [1:0] VEC_INTV = 2'b00, VEC_PRIV = 2'b01, VEC_ILL = 2'b10;

    typedef struct packed {
        logic [2:0] sr1;
        logic [2:0] sr2;
        logic [2:0] dr;
        logic       logic_we;
        logic [1:0] alu_ctl;
        logic       ena_alu;
        logic       flag_we;
        logic [1:0] sel_pc;
        logic       ld_pc;
        logic       ena_pc;
        logic       ena_pcm1;
        logic       sel_eab1;
        logic [1:0] sel_eab2;
        logic       sel_mar;
        logic       ena_marm;
        logic       ld_mar;
        logic       ld_mdr;
        logic       sel_mdr;
        logic       mem_we;
        logic       ena_mdr;
        logic       ld_ir;
        logic       ena_psr;
        logic       ena_sp;
        logic       ena_vector;
        logic       ld_saved_usp;
        logic       ld_saved_ssp;
        logic       ld_priority;
        logic       ld_vector;
        logic       ld_cc;
        logic       ld_priv;
        logic       set_priv;
        logic       sel_psrmux;
        logic [1:0] sel_spmux;
        logic [1:0] sel_vecmux;
    } ctrl_t;

endpackage

// File: rtl/lc3_controller.sv
// LC-3 Moore control FSM: one state register, separate next-state and
// output-decode blocks, outputs a pure function of the current state.
module lc3_controller
    import lc3_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] IR,
    input  logic        N,
    input  logic        Z,
    input  logic        P,
    input  logic        PRIV,
    input  logic        INT,
    input  logic        memRDY,
    output logic [2:0]  SR1,
    output logic [2:0]  SR2,
    output logic [2:0]  DR,
    output logic        logicWE,
    output logic [1:0]  aluControl,
    output logic        enaALU,
    output logic        flagWE,
    output logic [1:0]  selPC,
    output logic        ldPC,
    output logic        enaPC,
    output logic        enaPCM1,
    output logic        selEAB1,
    output logic [1:0]  selEAB2,
    output logic        selMAR,
    output logic        enaMARM,
    output logic        ldMAR,
    output logic        ldMDR,
    output logic        selMDR,
    output logic        memWE,
    output logic        enaMDR,
    output logic        ldIR,
    output logic        enaPSR,
    output logic        enaSP,
    output logic        enaVector,
    output logic        ldSavedUSP,
    output logic        ldSavedSSP,
    output logic        ldPriority,
    output logic        ldVector,
    output logic        ldCC,
    output logic        ldPriv,
    output logic        SetPriv,
    output logic        selPSRMUX,
    output logic [1:0]  selSPMUX,
    output logic [1:0]  selVectorMUX
);

    state_e state_q, state_d;
    ctrl_t  c;
    logic   ben;
    logic   unused_ir;

    // IR[5:3] only matter to the datapath (immediate select / unused field)
    assign unused_ir = ^IR[5:3];
    assign ben = (IR[11] & N) | (IR[10] & Z) | (IR[9] & P);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S18;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S18: state_d = INT ? S49 : S33;
            S33: if (memRDY) state_d = S35;
            S35: state_d = S32;
            S32: begin
                case (IR[15:12])
                    OP_BR:   state_d = S0;
                    OP_ADD:  state_d = S1;
                    OP_LD:   state_d = S2;
                    OP_ST:   state_d = S3;
                    OP_JSR:  state_d = S4;
                    OP_AND:  state_d = S5;
                    OP_LDR:  state_d = S6;
                    OP_STR:  state_d = S7;
                    OP_RTI:  state_d = S8;
                    OP_NOT:  state_d = S9;
                    OP_LDI:  state_d = S10;
                    OP_STI:  state_d = S11;
                    OP_JMP:  state_d = S12;
                    OP_RES:  state_d = S13;
                    OP_LEA:  state_d = S14;
                    default: state_d = S15;
                endcase
            end
            S0:                 state_d = ben ? S22 : S18;
            S2, S6, S26:        state_d = S25;
            S10:                state_d = S24;
            S24: if (memRDY)    state_d = S26;
            S25: if (memRDY)    state_d = S27;
            S3, S7, S31:        state_d = S23;
            S11:                state_d = S29;
            S29: if (memRDY)    state_d = S31;
            S23:                state_d = S16;
            S16: if (memRDY)    state_d = S18;
            S4:                 state_d = IR[11] ? S21 : S20;
            S15:                state_d = S28;
            S28: if (memRDY)    state_d = S30;
            S8:                 state_d = PRIV ? S44 : S36;
            S36: if (memRDY)    state_d = S38;
            S38:                state_d = S39;
            S39:                state_d = S40;
            S40: if (memRDY)    state_d = S42;
            S42:                state_d = S34;
            // PRIV here is the freshly restored PSR[15]
            S34:                state_d = PRIV ? S59 : S18;
            S49, S44, S13:      state_d = PRIV ? S45 : S37;
            S45:                state_d = S37;
            S37:                state_d = S41;
            S41: if (memRDY)    state_d = S43;
            S43:                state_d = S47;
            S47:                state_d = S48;
            S48: if (memRDY)    state_d = S50;
            S50:                state_d = S52;
            S52: if (memRDY)    state_d = S54;
            default:            state_d = S18;
        endcase
    end

    always_comb begin
        c = '0;
        case (state_q)
            S18: begin c.ld_mar = 1'b1; c.ena_pc = 1'b1; c.ld_pc = 1'b1; c.sel_pc = PC_INC; end
            S33, S24, S25, S29, S36, S40, S52: begin c.ld_mdr = 1'b1; c.sel_mdr = MDR_MEM; end
            // R7<-PC is folded into the trap-table read so the MARMUX and PC never share the bus
            S28: begin
                c.ld_mdr = 1'b1; c.sel_mdr = MDR_MEM;
                c.dr = 3'd7; c.logic_we = 1'b1; c.ena_pc = 1'b1;
            end
            S35: begin c.ena_mdr = 1'b1; c.ld_ir = 1'b1; end
            S1, S5, S9: begin
                c.sr1 = IR[8:6]; c.sr2 = IR[2:0]; c.dr = IR[11:9];
                c.logic_we = 1'b1; c.flag_we = 1'b1; c.ena_alu = 1'b1;
                c.alu_ctl = (state_q == S1) ? ALU_ADD : (state_q == S5) ? ALU_AND : ALU_NOT;
            end
            S14: begin
                c.dr = IR[11:9]; c.logic_we = 1'b1; c.flag_we = 1'b1;
                c.sel_eab1 = EAB1_PC; c.sel_eab2 = EAB2_OFF9; c.sel_mar = MAR_EAB; c.ena_marm = 1'b1;
            end
            S2, S3, S10, S11: begin
                c.ld_mar = 1'b1; c.sel_eab1 = EAB1_PC; c.sel_eab2 = EAB2_OFF9;
                c.sel_mar = MAR_EAB; c.ena_marm = 1'b1;
            end
            S6, S7: begin
                c.ld_mar = 1'b1; c.sr1 = IR[8:6]; c.sel_eab1 = EAB1_SR1; c.sel_eab2 = EAB2_OFF6;
                c.sel_mar = MAR_EAB; c.ena_marm = 1'b1;
            end
            S26, S31: begin c.ena_mdr = 1'b1; c.ld_mar = 1'b1; end
            S27: begin c.dr = IR[11:9]; c.logic_we = 1'b1; c.flag_we = 1'b1; c.ena_mdr = 1'b1; end
            S23: begin
                c.sr1 = IR[11:9]; c.alu_ctl = ALU_PASS; c.ena_alu = 1'b1;
                c.ld_mdr = 1'b1; c.sel_mdr = MDR_BUS;
            end
            S16, S41, S48: c.mem_we = 1'b1;
            S4:  begin c.dr = 3'd7; c.logic_we = 1'b1; c.ena_pc = 1'b1; end
            S21: begin c.ld_pc = 1'b1; c.sel_pc = PC_EAB; c.sel_eab1 = EAB1_PC; c.sel_eab2 = EAB2_OFF11; end
            S20, S12: begin
                c.ld_pc = 1'b1; c.sel_pc = PC_EAB; c.sr1 = IR[8:6];
                c.sel_eab1 = EAB1_SR1; c.sel_eab2 = EAB2_ZERO;
            end
            S22: begin c.ld_pc = 1'b1; c.sel_pc = PC_EAB; c.sel_eab1 = EAB1_PC; c.sel_eab2 = EAB2_OFF9; end
            S15: begin c.ld_mar = 1'b1; c.sel_mar = MAR_ZEXT; c.ena_marm = 1'b1; end
            S30, S38, S54: begin c.ena_mdr = 1'b1; c.ld_pc = 1'b1; c.sel_pc = PC_BUS; end
            S8: begin
                c.sr1 = 3'd6; c.sel_eab1 = EAB1_SR1; c.sel_eab2 = EAB2_ZERO;
                c.sel_mar = MAR_EAB; c.ena_marm = 1'b1; c.ld_mar = 1'b1;
            end
            S39: begin
                c.sr1 = 3'd6; c.sel_spmux = SP_INC; c.ena_sp = 1'b1;
                c.ld_mar = 1'b1; c.dr = 3'd6; c.logic_we = 1'b1;
            end
            S34: begin c.sr1 = 3'd6; c.sel_spmux = SP_INC; c.ena_sp = 1'b1; c.dr = 3'd6; c.logic_we = 1'b1; end
            S42: begin
                c.ena_mdr = 1'b1; c.ld_cc = 1'b1; c.ld_priv = 1'b1;
                c.ld_priority = 1'b1; c.sel_psrmux = PSR_BUS;
            end
            S59: begin
                c.sr1 = 3'd6; c.ld_saved_ssp = 1'b1; c.sel_spmux = SP_USP;
                c.ena_sp = 1'b1; c.dr = 3'd6; c.logic_we = 1'b1;
            end
            S49: begin
                c.ld_vector = 1'b1; c.sel_vecmux = VEC_INTV; c.ena_psr = 1'b1; c.ld_mdr = 1'b1;
                c.ld_priority = 1'b1; c.ld_priv = 1'b1; c.set_priv = 1'b1; c.sel_psrmux = PSR_INT;
            end
            S44: begin c.ld_vector = 1'b1; c.sel_vecmux = VEC_PRIV; c.ena_psr = 1'b1; c.ld_mdr = 1'b1; end
            S13: begin c.ld_vector = 1'b1; c.sel_vecmux = VEC_ILL;  c.ena_psr = 1'b1; c.ld_mdr = 1'b1; end
            S45: begin
                c.sr1 = 3'd6; c.ld_saved_usp = 1'b1; c.sel_spmux = SP_SSP;
                c.ena_sp = 1'b1; c.dr = 3'd6; c.logic_we = 1'b1;
            end
            S37, S47: begin
                c.sr1 = 3'd6; c.sel_spmux = SP_DEC; c.ena_sp = 1'b1;
                c.ld_mar = 1'b1; c.dr = 3'd6; c.logic_we = 1'b1;
            end
            S43: begin c.ena_pcm1 = 1'b1; c.ld_mdr = 1'b1; c.sel_mdr = MDR_BUS; end
            S50: begin c.ena_vector = 1'b1; c.ld_mar = 1'b1; end
            default: c = '0;
        endcase
    end

    assign SR1 = c.sr1;            assign SR2 = c.sr2;            assign DR = c.dr;
    assign logicWE = c.logic_we;   assign aluControl = c.alu_ctl; assign enaALU = c.ena_alu;
    assign flagWE = c.flag_we;     assign selPC = c.sel_pc;       assign ldPC = c.ld_pc;
    assign enaPC = c.ena_pc;       assign enaPCM1 = c.ena_pcm1;   assign selEAB1 = c.sel_eab1;
    assign selEAB2 = c.sel_eab2;   assign selMAR = c.sel_mar;     assign enaMARM = c.ena_marm;
    assign ldMAR = c.ld_mar;       assign ldMDR = c.ld_mdr;       assign selMDR = c.sel_mdr;
    assign memWE = c.mem_we;       assign enaMDR = c.ena_mdr;     assign ldIR = c.ld_ir;
    assign enaPSR = c.ena_psr;     assign enaSP = c.ena_sp;       assign enaVector = c.ena_vector;
    assign ldSavedUSP = c.ld_saved_usp;  assign ldSavedSSP = c.ld_saved_ssp;
    assign ldPriority = c.ld_priority;   assign ldVector = c.ld_vector;
    assign ldCC = c.ld_cc;         assign ldPriv = c.ld_priv;     assign SetPriv = c.set_priv;
    assign selPSRMUX = c.sel_psrmux;     assign selSPMUX = c.sel_spmux;
    assign selVectorMUX = c.sel_vecmux;

endmodule

// File: tb/tb_lc3_controller.sv
// Randomized bench for lc3_controller: an instruction-level model builds the
// expected state walk per instruction; key per-state outputs are checked too.
module tb_lc3_controller;

    logic clk_raw = 1'b0;
    logic clk_en  = 1'b1;
    logic clk;
    logic rst;
    logic [15:0] IR;
    logic N, Z, P, PRIV, INT, memRDY;
    logic [2:0] SR1, SR2, DR;
    logic logicWE, enaALU, flagWE, ldPC, enaPC, enaPCM1, selEAB1, selMAR, enaMARM;
    logic [1:0] aluControl, selPC, selEAB2, selSPMUX, selVectorMUX;
    logic ldMAR, ldMDR, selMDR, memWE, enaMDR, ldIR;
    logic enaPSR, enaSP, enaVector, ldSavedUSP, ldSavedSSP, ldPriority, ldVector;
    logic ldCC, ldPriv, SetPriv, selPSRMUX;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    assign clk = clk_raw & clk_en;
    always #5 clk_raw = ~clk_raw;

    lc3_controller dut (
        .clk(clk), .rst(rst), .IR(IR), .N(N), .Z(Z), .P(P), .PRIV(PRIV), .INT(INT),
        .memRDY(memRDY), .SR1(SR1), .SR2(SR2), .DR(DR), .logicWE(logicWE),
        .aluControl(aluControl), .enaALU(enaALU), .flagWE(flagWE), .selPC(selPC),
        .ldPC(ldPC), .enaPC(enaPC), .enaPCM1(enaPCM1), .selEAB1(selEAB1),
        .selEAB2(selEAB2), .selMAR(selMAR), .enaMARM(enaMARM), .ldMAR(ldMAR),
        .ldMDR(ldMDR), .selMDR(selMDR), .memWE(memWE), .enaMDR(enaMDR), .ldIR(ldIR),
        .enaPSR(enaPSR), .enaSP(enaSP), .enaVector(enaVector), .ldSavedUSP(ldSavedUSP),
        .ldSavedSSP(ldSavedSSP), .ldPriority(ldPriority), .ldVector(ldVector),
        .ldCC(ldCC), .ldPriv(ldPriv), .SetPriv(SetPriv), .selPSRMUX(selPSRMUX),
        .selSPMUX(selSPMUX), .selVectorMUX(selVectorMUX)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int cur_state();
        return int'(dut.state_q);
    endfunction

    function automatic bit is_wait(input int s);
        return s inside {33, 24, 25, 29, 36, 40, 28, 52, 16, 41, 48};
    endfunction

    task automatic step();
        @(posedge clk_raw);
        #1;
    endtask

    task automatic check_outs(input int s);
        int bus;
        bus = enaALU + enaPC + enaPCM1 + enaMARM + enaMDR + enaPSR + enaSP + enaVector;
        chk("one_bus_driver", 32'(bus <= 1), 1);
        chk("memWE_only_in_writes", memWE, 32'(s inside {16, 41, 48}));
        chk("ldIR_only_in_35", ldIR, 32'(s == 35));
        case (s)
            18: chk("s18_ctl", {ldMAR, enaPC, ldPC, selPC}, 5'b11100);
            33: chk("s33_ctl", {ldMDR, selMDR}, 2'b11);
            35: chk("s35_ctl", {enaMDR, ldIR}, 2'b11);
            1, 5, 9: begin
                chk("alu_we", {logicWE, flagWE, enaALU}, 3'b111);
                chk("alu_regs", {DR, SR1, SR2}, {IR[11:9], IR[8:6], IR[2:0]});
                chk("alu_op", aluControl, (s == 1) ? 2'b00 : (s == 5) ? 2'b01 : 2'b10);
            end
            22: chk("br_taken", {ldPC, selPC}, 3'b101);
            23: chk("st_pass", {enaALU, aluControl, ldMDR, SR1}, {4'b1111, IR[11:9]});
            27: chk("ld_wb", {logicWE, flagWE, enaMDR, DR}, {3'b111, IR[11:9]});
            49: chk("int_vec", {ldVector, selVectorMUX, ldPriv, SetPriv}, 5'b10011);
            44: chk("priv_vec", {ldVector, selVectorMUX}, 3'b101);
            13: chk("ill_vec", {ldVector, selVectorMUX}, 3'b110);
            43: chk("push_pcm1", {enaPCM1, ldMDR}, 2'b11);
            50: chk("vec_mar", {enaVector, ldMAR}, 2'b11);
            54: chk("vec_pc", {ldPC, selPC, enaMDR}, 4'b1101);
            default: ;
        endcase
    endtask

    task automatic exc_tail(input logic priv);
        if (priv) exp_q.push_back(45);
        exp_q.push_back(37); exp_q.push_back(41); exp_q.push_back(43); exp_q.push_back(47);
        exp_q.push_back(48); exp_q.push_back(50); exp_q.push_back(52); exp_q.push_back(54);
    endtask

    // Expected state walk for one instruction, derived from the opcode's datapath steps
    task automatic build(input logic [15:0] ir, input logic [2:0] nzp, input logic priv,
                         input logic intr, input logic upriv);
        exp_q.delete();
        if (intr) begin
            exp_q.push_back(49);
            exc_tail(priv);
        end else begin
            exp_q.push_back(33); exp_q.push_back(35); exp_q.push_back(32);
            case (int'(ir[15:12]))
                0: begin
                    exp_q.push_back(0);
                    if ((ir[11] & nzp[2]) | (ir[10] & nzp[1]) | (ir[9] & nzp[0])) exp_q.push_back(22);
                end
                1, 5, 9, 12, 14: exp_q.push_back(int'(ir[15:12]));
                2:  begin exp_q.push_back(2);  exp_q.push_back(25); exp_q.push_back(27); end
                6:  begin exp_q.push_back(6);  exp_q.push_back(25); exp_q.push_back(27); end
                10: begin exp_q.push_back(10); exp_q.push_back(24); exp_q.push_back(26);
                          exp_q.push_back(25); exp_q.push_back(27); end
                3:  begin exp_q.push_back(3);  exp_q.push_back(23); exp_q.push_back(16); end
                7:  begin exp_q.push_back(7);  exp_q.push_back(23); exp_q.push_back(16); end
                11: begin exp_q.push_back(11); exp_q.push_back(29); exp_q.push_back(31);
                          exp_q.push_back(23); exp_q.push_back(16); end
                4:  begin exp_q.push_back(4); exp_q.push_back(ir[11] ? 21 : 20); end
                15: begin exp_q.push_back(15); exp_q.push_back(28); exp_q.push_back(30); end
                8: begin
                    exp_q.push_back(8);
                    if (priv) begin
                        exp_q.push_back(44);
                        exc_tail(1'b1);
                    end else begin
                        exp_q.push_back(36); exp_q.push_back(38); exp_q.push_back(39);
                        exp_q.push_back(40); exp_q.push_back(42); exp_q.push_back(34);
                        if (upriv) exp_q.push_back(59);
                    end
                end
                default: begin exp_q.push_back(13); exc_tail(priv); end
            endcase
        end
        exp_q.push_back(18);
    endtask

    // Starts and ends in state 18; stall<0 draws random memory latency per access
    task automatic run_instr(input logic [15:0] ir, input logic [2:0] nzp, input logic priv,
                             input logic intr, input logic upriv, input int stall);
        int cur;
        int nxt;
        int waits;
        build(ir, nzp, priv, intr, upriv);
        IR = ir; {N, Z, P} = nzp; PRIV = priv;
        cur = 18;
        while (exp_q.size() > 0) begin
            INT = (cur == 18) ? intr : 1'($urandom_range(0, 1));
            if (cur == 42) PRIV = upriv;
            if (is_wait(cur)) begin
                waits = (stall < 0) ? $urandom_range(0, 3) : stall;
                for (int k = 0; k < waits; k++) begin
                    memRDY = 1'b0;
                    step();
                    chk("wait_hold", cur_state(), cur);
                    check_outs(cur);
                end
                memRDY = 1'b1;
            end else begin
                memRDY = 1'($urandom_range(0, 1));
            end
            nxt = exp_q.pop_front();
            step();
            chk($sformatf("state_after_%0d", cur), cur_state(), nxt);
            cur = nxt;
            check_outs(cur);
        end
        INT = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; IR = 16'h0000; {N, Z, P} = 3'b000; PRIV = 1'b0; INT = 1'b0; memRDY = 1'b0;
        repeat (3) step();
        chk("reset_state", cur_state(), 18);
        check_outs(18);
        chk("reset_quiet", {logicWE, ldMDR, enaMDR, ldVector, enaSP}, 5'b0);
        @(negedge clk_raw);
        rst = 1'b1;

        run_instr(16'h1261, 3'b000, 1'b0, 1'b0, 1'b0, 0);   // ADD R1,R1,#1
        run_instr(16'h0405, 3'b010, 1'b0, 1'b0, 1'b0, 0);   // BRz taken
        run_instr(16'h0405, 3'b101, 1'b0, 1'b0, 1'b0, 0);   // BRz not taken
        run_instr(16'h5A42, 3'b000, 1'b0, 1'b0, 1'b0, 5);   // AND with 5-cycle fetch stall
        run_instr(16'h7283, 3'b000, 1'b0, 1'b0, 1'b0, 3);   // STR with slow write
        run_instr(16'h8000, 3'b000, 1'b1, 1'b0, 1'b0, 0);   // RTI from user mode
        run_instr(16'h8000, 3'b000, 1'b0, 1'b0, 1'b1, 1);   // RTI back to user
        run_instr(16'h1261, 3'b000, 1'b0, 1'b1, 1'b0, 0);   // interrupt, supervisor
        run_instr(16'h1261, 3'b000, 1'b1, 1'b1, 1'b0, 2);   // interrupt, user
        run_instr(16'hD000, 3'b000, 1'b1, 1'b0, 1'b0, 0);   // illegal opcode

        // Clock gated off while in 33: state must hold even with memRDY=1
        IR = 16'h1261; INT = 1'b0; memRDY = 1'b0;
        step();
        chk("gate_pre", cur_state(), 33);
        @(negedge clk_raw);
        clk_en = 1'b0;
        memRDY = 1'b1;
        repeat (4) @(posedge clk_raw);
        #1;
        chk("gate_hold", cur_state(), 33);
        @(negedge clk_raw);
        clk_en = 1'b1;
        step(); chk("gate_resume", cur_state(), 35);
        step(); chk("gate_decode", cur_state(), 32);
        step(); chk("gate_add", cur_state(), 1);
        step(); chk("gate_fetch", cur_state(), 18);

        for (int i = 0; i < 300; i++) begin
            run_instr(16'($urandom), 3'($urandom), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
